cpu2_core: RTL and testbench
============================

Name: cpu2_core

Overview:
- Second-generation multicycle CPU core. Executes the 16-bit instruction format of the first-generation core: opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm9[8:0].
- Generalised in data width and PC width.
- Adds instruction-fetch handshake, program counter, ALU flags, conditional jump, HALT and a retired-instruction counter.
- Sits between the instruction memory/bench and the register-writeback observation port.

Parameters:
DATA_W, 16, register/ALU datapath width (>=9)
PC_W, 8, program counter width (<=9; jump target is imm9[PC_W-1:0])
CNT_W, 16, retired-instruction counter width

Ports:
ck  in  1  clock, rising edge
res  in  1  reset, asynchronous, active-low
inst_req  out  1  fetch request, high in FETCH only
pc  out  PC_W  address of instruction being fetched
inst_valid  in  1  inst is valid this cycle (sampled only while inst_req=1)
inst  in  16  instruction word
wb_en  out  1  one-cycle pulse when a register is written
wb_addr  out  3  destination register of write
wb_data  out  DATA_W  value written
flag_z  out  1  zero flag of last ALU op
flag_c  out  1  carry (ADD) / borrow (SUB) of last ALU op
halted  out  1  core stopped by HALT
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (res=0, async): state=FETCH; pc=0; all 8 registers=0; flags=0; wb_en=0; wb_addr=0; wb_data=0; halted=0; instret=0; inst_req=0 while res=0.
- FSM: FETCH -> DECODE -> EXEC -> WB -> FETCH. HALTED is terminal until reset.
- FETCH: inst_req=1. Stay in FETCH while inst_valid=0. On inst_valid=1, latch inst into IR and go to DECODE.
- DECODE: read rs1/rs2 (or rd for JZ) into operand latches.
- EXEC: ALU computes result; flags update for ADD/SUB/AND/OR only.
- WB: the register write and pc update happen on the same edge; instret+1 (wraps at 2^CNT_W).
- Minimum cost is 4 cycles per instruction with inst_valid held high. Each wait cycle in FETCH adds 1 cycle.
- Opcodes:
  - LOADI: rd = zero-extended imm9.
  - ADD: rd = rs1+rs2; flag_c = carry out of bit DATA_W-1.
  - SUB: rd = rs1-rs2; flag_c = 1 iff rs1<rs2 unsigned.
  - AND, OR: rd = rs1 op rs2; flag_c=0.
  - SHL, SHR: rd = rs1 shifted by 1, zero fill; flags unchanged.
  - JZ: if reg[rd]==0, pc = imm9[PC_W-1:0], else pc+1. No register write.
  - HALT: go to HALTED, halted=1, pc frozen, instret still increments for HALT, inst_req=0.
  - Undefined opcode: treated as NOP (pc+1, instret+1, no write).
- flag_z = (result==0), for ops that update flags.
- wb_en is high for exactly the WB cycle of register-writing ops. wb_addr/wb_data hold their last values otherwise.
- pc wraps modulo 2^PC_W.
- Writes to rd take effect before the next DECODE, so no hazards exist (strictly sequential).
- Same register as rs1, rs2 and rd is legal; old values are used.
- inst changing while inst_req=0 is ignored.
- Reset mid-instruction aborts it: no partial write, all state returns to reset values.

Decomposition:
- Shared define file gains OP_AND, OP_OR, OP_SHL, OP_SHR, OP_JZ, OP_HALT alongside the existing OP_LOADI/OP_ADD/OP_SUB.
- Shared define file also holds the FSM state encodings and field bit positions.
- Sub-module cpu2_regfile: 8 x DATA_W registers, two async read ports, one sync write port, async active-low clear.
- ALU stays inline in cpu2_core.

Test Plan:
- LOADI r1,5; LOADI r2,3; ADD r3,r1,r2; SUB r3,r3,r1 with inst_valid always 1 -> wb pulses (1,5),(2,3),(3,8),(3,3). Each instruction takes 4 cycles. flag_c=0 after SUB, instret=4, pc=4.
- r1=5, r2=3; SUB r4,r2,r1 -> wb_data=0xFFFE, flag_c=1, flag_z=0. Then LOADI r5,0xFF; ADD r5,r5,r5 ... repeated to 0x8000; ADD r6,r5,r5 -> 0x0000, flag_c=1, flag_z=1.
- JZ r0,0x10 with r0=0 -> next pc=0x10. JZ r1,0x20 with r1=5 -> pc=0x11. wb_en stays 0 for both.
- Hold inst_valid=0 for 3 cycles in FETCH -> inst_req stays 1, pc stable. The instruction completes 7 cycles after FETCH entry.
- HALT -> halted=1 after WB, inst_req=0 forever, instret incremented. Further inst_valid pulses are ignored.
- Drive res=0 asynchronously mid-EXEC of ADD r3 -> no wb_en. All outputs reset immediately (before the next clock edge). After release, fetch resumes at pc=0.

Source files
------------

// File: rtl/cpu2_pkg.sv
// cpu2_pkg: opcodes, instruction field positions, FSM state encoding and
// decode helpers shared by the cpu2 core and its register file.
package cpu2_pkg;

  localparam int INST_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = 3;
  localparam int IMM_W  = 9;

  // Instruction field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  // Opcodes; every other encoding executes as a NOP
  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM_W-1:0]  imm;
  } dec_t;

  // Split an instruction word into its (overlapping) fields
  function automatic dec_t decode(input logic [INST_W-1:0] w);
    dec_t d;
    d.op  = w[OPC_MSB:OPC_LSB];
    d.rd  = w[RD_MSB:RD_LSB];
    d.rs1 = w[RS1_MSB:RS1_LSB];
    d.rs2 = w[RS2_MSB:RS2_LSB];
    d.imm = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

  // Ops that produce a register write in WB
  function automatic logic writes_reg(input logic [3:0] op);
    logic r;
    case (op)
      OP_LOADI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops that update the Z/C flags (shifts deliberately leave them alone)
  function automatic logic sets_flags(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // JZ tests the register named by rd, so rd is routed to read port A
  function automatic logic reads_rd(input logic [3:0] op);
    return (op == OP_JZ);
  endfunction

endpackage

// File: rtl/cpu2_regfile.sv
// cpu2_regfile: 8 x DATA_W register file, two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
module cpu2_regfile
  import cpu2_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              ck,
  input  logic              res,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage: cleared on reset, written on the edge that ends WB
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu2_core.sv
// cpu2_core: strictly sequential multicycle CPU core.
// FETCH -> DECODE -> EXEC -> WB -> FETCH, with HALTED as a terminal state.
// The writeback port (wb_en/wb_addr/wb_data) is presented during the WB
// cycle and the register file commits it on the edge that ends WB, the same
// edge that advances pc and instret.
module cpu2_core
  import cpu2_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              ck,
  input  logic              res,
  output logic              inst_req,
  output logic [PC_W-1:0]   pc,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic [CNT_W-1:0]  instret
);

  state_e            state;
  logic [INST_W-1:0] ir;
  dec_t              dec;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [REG_AW-1:0] raddr_a;
  logic [DATA_W:0]   alu_out;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout;
  logic              jz_taken;
  logic [PC_W-1:0]   pc_next;

  // ALU: returns {carry/borrow, result}; the top bit is only meaningful
  // for ADD and SUB.
  function automatic logic [DATA_W:0] alu(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [IMM_W-1:0]  imm
  );
    logic [DATA_W:0] r;
    r = '0;
    case (op)
      OP_LOADI: r = {1'b0, DATA_W'(imm)};
      OP_ADD:   r = {1'b0, a} + {1'b0, b};
      OP_SUB:   r = {1'b0, a} - {1'b0, b};  // top bit set iff a < b unsigned
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_SHL:   r = {1'b0, a << 1};
      OP_SHR:   r = {1'b0, a >> 1};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign dec      = decode(ir);
  assign raddr_a  = reads_rd(dec.op) ? dec.rd : dec.rs1;
  assign alu_out  = alu(dec.op, opa, opb, dec.imm);
  assign alu_res  = alu_out[DATA_W-1:0];
  assign alu_cout = alu_out[DATA_W];
  assign jz_taken = (dec.op == OP_JZ) && (opa == '0);
  assign pc_next  = jz_taken ? dec.imm[PC_W-1:0] : pc + PC_W'(1);

  // Fetch request is a pure state decode, forced low while reset is held
  assign inst_req = (state == S_FETCH) && res;

  cpu2_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .ck      (ck),
    .res     (res),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (raddr_a),
    .raddr_b (dec.rs2),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Control FSM with all architectural state and registered outputs
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state   <= S_FETCH;
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      pc      <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      halted  <= 1'b0;
      instret <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (inst_valid) begin
            ir    <= inst;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa   <= rdata_a;
          opb   <= rdata_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (writes_reg(dec.op)) begin
            wb_en   <= 1'b1;
            wb_addr <= dec.rd;
            wb_data <= alu_res;
          end
          if (sets_flags(dec.op)) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_cout;
          end
          state <= S_WB;
        end
        S_WB: begin
          wb_en   <= 1'b0;
          instret <= instret + CNT_W'(1);
          if (dec.op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            pc    <= pc_next;
            state <= S_FETCH;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu2_core.sv
// tb_cpu2_core: directed-vector bench for cpu2_core with hand-computed
// expected writebacks, flags, pc and retired counts.
module tb_cpu2_core;

  localparam int DATA_W = 16;
  localparam int PC_W   = 8;
  localparam int CNT_W  = 16;

  localparam logic [3:0] T_LOADI = 4'h1;
  localparam logic [3:0] T_ADD   = 4'h2;
  localparam logic [3:0] T_SUB   = 4'h3;
  localparam logic [3:0] T_AND   = 4'h4;
  localparam logic [3:0] T_OR    = 4'h5;
  localparam logic [3:0] T_SHL   = 4'h6;
  localparam logic [3:0] T_SHR   = 4'h7;
  localparam logic [3:0] T_JZ    = 4'h8;
  localparam logic [3:0] T_UNDEF = 4'h9;
  localparam logic [3:0] T_HALT  = 4'hF;

  logic              ck = 1'b0;
  logic              res = 1'b0;
  logic              inst_valid = 1'b0;
  logic [15:0]       inst = 16'h0000;
  logic              inst_req;
  logic [PC_W-1:0]   pc;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flag_z;
  logic              flag_c;
  logic              halted;
  logic [CNT_W-1:0]  instret;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic              got_en;
  logic [2:0]        got_addr;
  logic [DATA_W-1:0] got_data;
  int                early;
  int                t_req;
  bit                req_ok;

  cpu2_core #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .ck         (ck),
    .res        (res),
    .inst_req   (inst_req),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [8:0] imm);
    return {op, rd, imm};
  endfunction

  // Bounded wait (on falling edges) for the core to request a fetch
  task automatic wait_req();
    int n;
    n = 0;
    while (!inst_req && n < 12) begin
      @(negedge ck);
      n++;
    end
    req_ok = inst_req;
    t_req = cyc;
    if (!req_ok) check("req_timeout", {31'b0, inst_req}, 32'd1);
  endtask

  // Feed one instruction (after 'waits' idle FETCH cycles) and sample the
  // DECODE, EXEC and WB cycles on their falling edges.
  task automatic do_instr(input logic [15:0] w, input int waits);
    logic [PC_W-1:0] pc0;
    wait_req();
    got_en = 1'b0;
    got_addr = '0;
    got_data = '0;
    early = 0;
    if (!req_ok) return;
    pc0 = pc;
    for (int i = 0; i < waits; i++) begin
      inst_valid = 1'b0;
      inst = ~w;
      @(negedge ck);
      if (!inst_req || pc !== pc0) early++;
    end
    inst = w;
    inst_valid = 1'b1;
    @(posedge ck);
    // A HALT word with valid high outside FETCH must be ignored
    @(negedge ck);
    inst = 16'hF000;
    inst_valid = 1'b1;
    early += int'(wb_en) + int'(inst_req);
    @(negedge ck);
    early += int'(wb_en) + int'(inst_req);
    @(negedge ck);
    inst_valid = 1'b0;
    inst = 16'h0000;
    got_en = wb_en;
    got_addr = wb_addr;
    got_data = wb_data;
    early += int'(inst_req);
  endtask

  task automatic run(input string tag, input logic [15:0] w, input int waits,
                     input logic exp_en, input logic [2:0] exp_addr,
                     input logic [DATA_W-1:0] exp_data);
    do_instr(w, waits);
    check({tag, "_wben"}, {31'b0, got_en}, {31'b0, exp_en});
    if (exp_en) begin
      check({tag, "_addr"}, {29'b0, got_addr}, {29'b0, exp_addr});
      check({tag, "_data"}, {16'b0, got_data}, {16'b0, exp_data});
    end
    check({tag, "_early"}, early, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] m;
    logic              mc;
    int                t0;

    // Reset values while res is held low
    #12;
    check("rst_req", {31'b0, inst_req}, 32'd0);
    check("rst_pc", {24'b0, pc}, 32'd0);
    check("rst_wben", {31'b0, wb_en}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_instret", {16'b0, instret}, 32'd0);
    check("rst_flags", {30'b0, flag_z, flag_c}, 32'd0);
    @(negedge ck);
    res = 1'b1;

    // Basic sequence, four cycles per instruction
    wait_req();
    t0 = t_req;
    run("loadi_r1", enc_i(T_LOADI, 3'd1, 9'd5), 0, 1'b1, 3'd1, 16'd5);
    run("loadi_r2", enc_i(T_LOADI, 3'd2, 9'd3), 0, 1'b1, 3'd2, 16'd3);
    run("add_r3", enc_r(T_ADD, 3'd3, 3'd1, 3'd2), 0, 1'b1, 3'd3, 16'd8);
    run("sub_r3", enc_r(T_SUB, 3'd3, 3'd3, 3'd1), 0, 1'b1, 3'd3, 16'd3);
    wait_req();
    check("cpi4", t_req - t0, 32'd16);
    check("seq_flags", {30'b0, flag_z, flag_c}, 32'd0);
    check("seq_instret", {16'b0, instret}, 32'd4);
    check("seq_pc", {24'b0, pc}, 32'd4);

    // Borrow
    run("sub_borrow", enc_r(T_SUB, 3'd4, 3'd2, 3'd1), 0, 1'b1, 3'd4, 16'hFFFE);
    wait_req();
    check("borrow_flags", {30'b0, flag_z, flag_c}, 32'b01);

    // Doubling chain up to 0x8000, then overflow to zero
    run("loadi_ff", enc_i(T_LOADI, 3'd5, 9'h0FF), 0, 1'b1, 3'd5, 16'h00FF);
    m = 16'h00FF;
    mc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mc = m[15];
      m = m << 1;
      run("dbl", enc_r(T_ADD, 3'd5, 3'd5, 3'd5), 0, 1'b1, 3'd5, m);
    end
    wait_req();
    check("dbl_end", {16'b0, m}, 32'h8000);
    check("dbl_flags", {30'b0, flag_z, flag_c}, {30'b0, 1'b0, mc});
    run("add_ovf", enc_r(T_ADD, 3'd6, 3'd5, 3'd5), 0, 1'b1, 3'd6, 16'h0000);
    wait_req();
    check("ovf_flags", {30'b0, flag_z, flag_c}, 32'b11);

    // Shifts leave flags alone; logic ops clear carry
    run("shl", enc_r(T_SHL, 3'd7, 3'd1, 3'd0), 0, 1'b1, 3'd7, 16'd10);
    run("shr", enc_r(T_SHR, 3'd7, 3'd4, 3'd0), 0, 1'b1, 3'd7, 16'h7FFF);
    wait_req();
    check("shift_flags", {30'b0, flag_z, flag_c}, 32'b11);
    run("and", enc_r(T_AND, 3'd7, 3'd1, 3'd2), 0, 1'b1, 3'd7, 16'd1);
    wait_req();
    check("and_flags", {30'b0, flag_z, flag_c}, 32'b00);
    run("or", enc_r(T_OR, 3'd7, 3'd1, 3'd2), 0, 1'b1, 3'd7, 16'd7);
    run("and_zero", enc_r(T_AND, 3'd7, 3'd1, 3'd0), 0, 1'b1, 3'd7, 16'd0);
    wait_req();
    check("andz_flags", {30'b0, flag_z, flag_c}, 32'b10);

    // Undefined opcode acts as NOP
    run("undef", enc_i(T_UNDEF, 3'd3, 9'h123), 0, 1'b0, 3'd0, 16'd0);
    wait_req();
    check("nop_pc", {24'b0, pc}, 32'd28);
    check("nop_instret", {16'b0, instret}, 32'd28);

    // Conditional jumps
    run("jz_taken", enc_i(T_JZ, 3'd0, 9'h010), 0, 1'b0, 3'd0, 16'd0);
    wait_req();
    check("jz_taken_pc", {24'b0, pc}, 32'h10);
    run("jz_not", enc_i(T_JZ, 3'd1, 9'h020), 0, 1'b0, 3'd0, 16'd0);
    wait_req();
    check("jz_not_pc", {24'b0, pc}, 32'h11);

    // Fetch stalls: three idle cycles stretch the instruction to seven
    t0 = t_req;
    run("stall", enc_i(T_LOADI, 3'd2, 9'h1A5), 3, 1'b1, 3'd2, 16'h01A5);
    wait_req();
    check("stall_cycles", t_req - t0, 32'd7);
    check("stall_pc", {24'b0, pc}, 32'h12);

    // Same register as both sources and destination
    run("add_same", enc_r(T_ADD, 3'd1, 3'd1, 3'd1), 0, 1'b1, 3'd1, 16'd10);
    run("sub_neg", enc_r(T_SUB, 3'd6, 3'd0, 3'd1), 0, 1'b1, 3'd6, 16'hFFF6);
    wait_req();
    check("pre_rst_instret", {16'b0, instret}, 32'd33);
    check("pre_rst_pc", {24'b0, pc}, 32'h14);
    check("pre_rst_c", {31'b0, flag_c}, 32'd1);

    // Asynchronous reset in the EXEC cycle of ADD r3,r1,r2
    inst = enc_r(T_ADD, 3'd3, 3'd1, 3'd2);
    inst_valid = 1'b1;
    @(posedge ck);
    @(negedge ck);
    inst_valid = 1'b0;
    @(negedge ck);
    #2;
    res = 1'b0;
    #1;
    check("arst_wben", {31'b0, wb_en}, 32'd0);
    check("arst_req", {31'b0, inst_req}, 32'd0);
    check("arst_pc", {24'b0, pc}, 32'd0);
    check("arst_instret", {16'b0, instret}, 32'd0);
    check("arst_flags", {30'b0, flag_z, flag_c}, 32'd0);
    check("arst_wb", {13'b0, wb_addr, wb_data}, 32'd0);
    @(posedge ck);
    #1;
    check("arst_hold", {30'b0, wb_en, inst_req}, 32'd0);
    @(negedge ck);
    res = 1'b1;
    #1;
    check("rel_req", {31'b0, inst_req}, 32'd1);
    check("rel_pc", {24'b0, pc}, 32'd0);

    // Registers were cleared: r1+r2 is now zero
    run("post_add", enc_r(T_ADD, 3'd3, 3'd1, 3'd2), 0, 1'b1, 3'd3, 16'd0);
    wait_req();
    check("post_flags", {30'b0, flag_z, flag_c}, 32'b10);
    check("post_pc", {24'b0, pc}, 32'd1);
    run("post_loadi", enc_i(T_LOADI, 3'd4, 9'd7), 0, 1'b1, 3'd4, 16'd7);

    // pc wraps modulo 2^PC_W
    run("jz_ff", enc_i(T_JZ, 3'd0, 9'h0FF), 0, 1'b0, 3'd0, 16'd0);
    wait_req();
    check("jz_ff_pc", {24'b0, pc}, 32'hFF);
    run("wrap_nop", enc_i(T_UNDEF, 3'd0, 9'h000), 0, 1'b0, 3'd0, 16'd0);
    wait_req();
    check("wrap_pc", {24'b0, pc}, 32'd0);
    run("nop2", enc_i(T_UNDEF, 3'd0, 9'h000), 0, 1'b0, 3'd0, 16'd0);

    // HALT is terminal
    run("halt", enc_i(T_HALT, 3'd0, 9'h000), 0, 1'b0, 3'd0, 16'd0);
    check("halt_wb_halted", {31'b0, halted}, 32'd0);
    @(negedge ck);
    check("halted", {31'b0, halted}, 32'd1);
    check("halt_req", {31'b0, inst_req}, 32'd0);
    check("halt_instret", {16'b0, instret}, 32'd6);
    check("halt_pc", {24'b0, pc}, 32'd1);
    early = 0;
    for (int i = 0; i < 6; i++) begin
      inst = enc_i(T_LOADI, 3'd1, 9'h055);
      inst_valid = (i % 2) == 0;
      @(negedge ck);
      early += int'(wb_en) + int'(inst_req);
    end
    inst_valid = 1'b0;
    check("halt_ignore", early, 0);
    check("halt_stay_instret", {16'b0, instret}, 32'd6);
    check("halt_stay_pc", {24'b0, pc}, 32'd1);
    check("halt_stay", {31'b0, halted}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
